// File: rtl/acq_pkg.sv
// Shared types and widths for the ADC acquisition path.
package acq_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } axis_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO of stream words (data + last); head is visible while not empty.
module sync_fifo_fwft
  import acq_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  axis_word_t din,
  input  logic       pop,
  output axis_word_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  axis_word_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           wr_en;
  logic           rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs pairs of sign-extended ADC samples into 32-bit AXI-Stream words.
// Define ADC_SAMPLE_PACKER_TEST_PATTERN_EN to replace adc_data with an internal 16-bit ramp.
module adc_sample_packer
  import acq_pkg::*;
#(
  parameter int unsigned ADC_W      = 14,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rst_pck,
  input  logic [31:0]       nb_of_sample,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  output logic [WORD_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       sample_cnt
);

  state_t              state, state_nxt;
  logic [31:0]         n_lat;
  logic [SAMPLE_W-1:0] pair_lo;
  logic                half;
  logic                last_pend;
  logic [WORD_W-1:0]   last_word;

  logic [SAMPLE_W-1:0] sample_c;
  logic                accept_c;
  logic                is_last_c;
  logic                word_done_c;
  logic [WORD_W-1:0]   word_c;
  logic [31:0]         cnt_inc_c;
  logic                space_c;
  logic                fifo_push_c;
  logic                fifo_pop_c;
  axis_word_t          fifo_din_c;
  axis_word_t          fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;

`ifdef ADC_SAMPLE_PACKER_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] ramp;

  assign sample_c = ramp;

  // Ramp restarts at 0 for every run and advances per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       ramp <= '0;
    else if (rst_pck || state == IDLE) ramp <= '0;
    else if (accept_c)                ramp <= ramp + SAMPLE_W'(1);
  end
`else
  assign sample_c = SAMPLE_W'($signed(adc_data));
`endif

  assign accept_c    = (state == RUN) && adc_valid;
  assign cnt_inc_c   = sample_cnt + 32'd1;
  assign is_last_c   = accept_c && (cnt_inc_c == n_lat);
  assign word_done_c = accept_c && (half || is_last_c);
  assign word_c      = half ? {sample_c, pair_lo} : {SAMPLE_W'(0), sample_c};

  assign fifo_pop_c    = m_axis_tvalid && m_axis_tready;
  assign space_c       = !fifo_full || fifo_pop_c;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout.data;
  assign m_axis_tlast  = fifo_dout.last;

  // New words go straight into the buffer; a deferred final word waits for space.
  always_comb begin
    fifo_push_c = 1'b0;
    fifo_din_c  = '0;
    if (word_done_c) begin
      fifo_din_c  = '{last: is_last_c, data: word_c};
      fifo_push_c = space_c;
    end else if (last_pend) begin
      fifo_din_c  = '{last: 1'b1, data: last_word};
      fifo_push_c = space_c;
    end
  end

  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (rst_pck),
    .push  (fifo_push_c),
    .din   (fifo_din_c),
    .pop   (fifo_pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rst_pck) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = (nb_of_sample == 32'd0) ? DONE : RUN;
        RUN:     if (is_last_c) state_nxt = DRAIN;
        DRAIN:   if (fifo_pop_c && m_axis_tlast) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Run bookkeeping: count latch, pairing, sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat      <= '0;
      sample_cnt <= '0;
      pair_lo    <= '0;
      half       <= 1'b0;
      last_pend  <= 1'b0;
      last_word  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else if (rst_pck) begin
      sample_cnt <= '0;
      pair_lo    <= '0;
      half       <= 1'b0;
      last_pend  <= 1'b0;
      last_word  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (state == IDLE) n_lat <= nb_of_sample;
      if (accept_c) begin
        sample_cnt <= cnt_inc_c;
        if (!half && !is_last_c) begin
          pair_lo <= sample_c;
          half    <= 1'b1;
        end else begin
          half    <= 1'b0;
        end
      end
      if (word_done_c && !space_c) begin
        if (is_last_c) begin
          last_pend <= 1'b1;
          last_word <= word_c;
        end else begin
          overflow  <= 1'b1;
        end
      end
      if (last_pend && !word_done_c && space_c) last_pend <= 1'b0;
      if (state == DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed self-checking bench for adc_sample_packer (ADC_W=14, FIFO_DEPTH=2).
module tb_adc_sample_packer;
  import acq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_pck = 1'b1;
  logic [31:0] nb_of_sample = '0;
  logic [13:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        done;
  logic        overflow;
  logic [31:0] sample_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  adc_sample_packer #(.ADC_W(14), .FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_pck       (rst_pck),
    .nb_of_sample  (nb_of_sample),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .done          (done),
    .overflow      (overflow),
    .sample_cnt    (sample_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so a negedge view predicts the next handshake.
  always @(negedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [31:0] n);
    rst_pck = 1'b1;
    adc_valid = 1'b0;
    tick();
    nb_of_sample = n;
    rst_pck = 1'b0;
    got_q.delete();
    tick();
  endtask

  task automatic feed(input int n, input logic [13:0] first);
    for (int i = 0; i < n; i++) begin
      adc_data  = first + 14'(i);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #2;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check("rst_done",   64'(done),          64'd0);
    check("rst_ovf",    64'(overflow),      64'd0);
    check("rst_cnt",    64'(sample_cnt),    64'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef ADC_SAMPLE_PACKER_TEST_PATTERN_EN
    m_axis_tready = 1'b1;
    begin_run(32'd4);
    for (int i = 0; i < 4; i++) begin
      adc_data  = 14'($urandom);
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
    wait_done("tp_done", 40);
    exp_q = '{{1'b0, 32'h0001_0000}, {1'b1, 32'h0003_0002}};
    check_words("tp");
`else
    // Eight continuous samples, free-flowing sink
    m_axis_tready = 1'b1;
    begin_run(32'd8);
    feed(8, 14'd1);
    wait_done("t1_done", 40);
    exp_q = '{{1'b0, 32'h0002_0001}, {1'b0, 32'h0004_0003},
              {1'b0, 32'h0006_0005}, {1'b1, 32'h0008_0007}};
    check_words("t1");
    check("t1_cnt", 64'(sample_cnt), 64'd8);
    check("t1_ovf", 64'(overflow), 64'd0);

    // Odd count with sign extension; final word visible one cycle after last sample
    begin_run(32'd3);
    adc_valid = 1'b1;
    adc_data = 14'h1FFF; tick();
    adc_data = 14'h2000; tick();
    adc_data = 14'h0005; tick();
    adc_valid = 1'b0;
    check("t2_tail_data", 64'(m_axis_tdata), 64'h0000_0005);
    check("t2_tail_last", 64'(m_axis_tlast), 64'd1);
    wait_done("t2_done", 40);
    exp_q = '{{1'b0, 32'hE000_1FFF}, {1'b1, 32'h0000_0005}};
    check_words("t2");

    // Zero-length run
    rst_pck = 1'b1;
    tick();
    nb_of_sample = 32'd0;
    rst_pck = 1'b0;
    got_q.delete();
    tick();
    check("t3_state", 64'(dut.state), 64'(DONE));
    check("t3_done_e1", 64'(done), 64'd0);
    tick();
    check("t3_done_e2", 64'(done), 64'd1);
    check("t3_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t3_words", 64'(got_q.size()), 64'd0);

    // Stalled sink: overflow, then the held final word still arrives
    m_axis_tready = 1'b0;
    begin_run(32'd16);
    feed(16, 14'd1);
    check("t4_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_cnt", 64'(sample_cnt), 64'd16);
    check("t4_state", 64'(dut.state), 64'(DRAIN));
    tick();
    tick();
    check("t4_hold_data", 64'(m_axis_tdata), 64'h0002_0001);
    check("t4_hold_last", 64'(m_axis_tlast), 64'd0);
    check("t4_not_done", 64'(done), 64'd0);
    m_axis_tready = 1'b1;
    wait_done("t4_done", 40);
    exp_q = '{{1'b0, 32'h0002_0001}, {1'b0, 32'h0004_0003}, {1'b1, 32'h0010_000F}};
    check_words("t4");

    // Abort mid-run, then a clean restart
    begin_run(32'd100);
    feed(10, 14'd1);
    rst_pck = 1'b1;
    tick();
    check("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t5_cnt", 64'(sample_cnt), 64'd0);
    check("t5_state", 64'(dut.state), 64'(IDLE));
    begin_run(32'd2);
    adc_valid = 1'b1;
    adc_data = 14'd7; tick();
    adc_data = 14'd9; tick();
    adc_valid = 1'b0;
    wait_done("t5_done", 40);
    exp_q = '{{1'b1, 32'h0009_0007}};
    check_words("t5");
    check("t5_ovf", 64'(overflow), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
